// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared constants and state type for the voice mixer
package synth_pkg;

  localparam int NUM_VOICES = 13;
  localparam int SAMPLE_W   = 8;
  localparam int OUT_W      = 12;
  localparam int IDX_W      = 4;

  // Full-scale value of the mixed sample; the accumulator clamps here.
  localparam logic [OUT_W-1:0] MIX_MAX = {OUT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OUT
  } mix_state_t;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - unsigned saturating adder, wide accumulator plus narrow sample
module sat_add
  import synth_pkg::*;
#(
  parameter int ACC_W = OUT_W,
  parameter int ADD_W = SAMPLE_W
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ADD_W-1:0] i_add,
  output logic [ACC_W-1:0] o_sum
);

  // One extra bit catches the carry; any carry means the result is clamped to full scale.
  logic [ACC_W:0] w_sum;

  assign w_sum = {1'b0, i_acc} + (ACC_W+1)'(i_add);
  assign o_sum = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

endmodule

// File: rtl/voice_mix_sequencer.sv
// rtl/voice_mix_sequencer.sv - serial voice poller with saturating mix and output handshake
module voice_mix_sequencer
  import synth_pkg::*;
#(
  parameter int VOICES = NUM_VOICES,
  parameter int S_W    = SAMPLE_W,
  parameter int O_W    = OUT_W,
  parameter int I_W    = IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic [VOICES-1:0] voice_en,
  output logic [I_W-1:0]    voice_sel,
  output logic              voice_req,
  input  logic              voice_ack,
  input  logic [S_W-1:0]    voice_sample,
  output logic [O_W-1:0]    mixed_sample,
  output logic              mixed_valid,
  input  logic              mixed_ready,
  output logic              busy,
  output logic              overrun
);

  mix_state_t        r_state;
  mix_state_t        w_state_nxt;
  logic [I_W-1:0]    r_idx;
  logic [O_W-1:0]    r_acc;
  logic [VOICES-1:0] r_en_q;
  logic [O_W-1:0]    r_mixed_sample;
  logic              r_mixed_valid;
  logic              r_overrun;

  logic              w_req;
  logic              w_take;
  logic              w_advance;
  logic              w_last;
  logic [O_W-1:0]    w_sum;

  sat_add #(
    .ACC_W(O_W),
    .ADD_W(S_W)
  ) u_sat_add (
    .i_acc(r_acc),
    .i_add(voice_sample),
    .o_sum(w_sum)
  );

  assign w_last = (r_idx == I_W'(VOICES - 1));
  assign w_take = w_req & voice_ack;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, request and advance decode; a disabled voice is skipped in one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        if (sample_tick) begin
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        w_req     = r_en_q[r_idx];
        w_advance = !r_en_q[r_idx] || voice_ack;
        if (w_advance && w_last) begin
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        if (mixed_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: snapshot the enable mask at the tick, accumulate on acks, latch the finished mix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx          <= '0;
      r_acc          <= '0;
      r_en_q         <= '0;
      r_mixed_sample <= '0;
      r_mixed_valid  <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_overrun <= sample_tick && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (sample_tick) begin
            r_acc  <= '0;
            r_idx  <= '0;
            r_en_q <= voice_en;
          end
        end
        SCAN: begin
          if (w_take) begin
            r_acc <= w_sum;
          end
          if (w_advance) begin
            if (w_last) begin
              r_mixed_sample <= w_take ? w_sum : r_acc;
              r_mixed_valid  <= 1'b1;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        OUT: begin
          if (mixed_ready) begin
            r_mixed_valid <= 1'b0;
          end
        end
        default: begin
          r_mixed_valid <= 1'b0;
        end
      endcase
    end
  end

  assign voice_sel    = r_idx;
  assign voice_req    = w_req;
  assign mixed_sample = r_mixed_sample;
  assign mixed_valid  = r_mixed_valid;
  assign busy         = (r_state != IDLE);
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_voice_mix_sequencer.sv
// tb/tb_voice_mix_sequencer.sv - scoreboard bench for voice_mix_sequencer
module tb_voice_mix_sequencer;

  typedef struct {
    int sample;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic        tick_a = 1'b0;
  logic [12:0] en_a = '0;
  logic [3:0]  sel_a;
  logic        req_a;
  logic        ack_a = 1'b0;
  logic [7:0]  smp_a = '0;
  logic [11:0] mix_a;
  logic        val_a;
  logic        rdy_a = 1'b0;
  logic        busy_a;
  logic        ovr_a;

  logic        tick_b = 1'b0;
  logic [12:0] en_b = '0;
  logic [3:0]  sel_b;
  logic        req_b;
  logic        ack_b = 1'b0;
  logic [7:0]  smp_b = '0;
  logic [7:0]  mix_b;
  logic        val_b;
  logic        rdy_b = 1'b1;
  logic        busy_b;
  logic        ovr_b;

  voice_mix_sequencer u_dut_a (
    .clk(clk), .rst(rst), .sample_tick(tick_a), .voice_en(en_a),
    .voice_sel(sel_a), .voice_req(req_a), .voice_ack(ack_a), .voice_sample(smp_a),
    .mixed_sample(mix_a), .mixed_valid(val_a), .mixed_ready(rdy_a),
    .busy(busy_a), .overrun(ovr_a)
  );

  voice_mix_sequencer #(.O_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .sample_tick(tick_b), .voice_en(en_b),
    .voice_sel(sel_b), .voice_req(req_b), .voice_ack(ack_b), .voice_sample(smp_b),
    .mixed_sample(mix_b), .mixed_valid(val_b), .mixed_ready(rdy_b),
    .busy(busy_b), .overrun(ovr_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int tick_cyc_a = 0;
  int tick_cyc_b = 0;
  int ovr_cnt = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  int tbl_a[16];
  int tbl_b[16];
  int wait_a = 0;
  int wcnt_a = 0;
  logic junk_a = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Voice responder A: acks after wait_a stall cycles; drives a stray ack when not requested if junk_a.
  always @(negedge clk) begin
    if (ack_a) wcnt_a = 0;
    if (req_a) begin
      if (wcnt_a == wait_a) begin
        ack_a = 1'b1;
        smp_a = 8'(tbl_a[sel_a]);
      end else begin
        ack_a = 1'b0;
        smp_a = 8'hFF;
        wcnt_a++;
      end
    end else begin
      ack_a  = junk_a;
      smp_a  = 8'hFF;
      wcnt_a = 0;
    end
  end

  // Voice responder B: zero-wait.
  always @(negedge clk) begin
    ack_b = req_b;
    smp_b = req_b ? 8'(tbl_b[sel_b]) : 8'h00;
  end

  always @(negedge clk) if (ovr_a) ovr_cnt++;

  // Monitor A: on each rising mixed_valid pop the next expectation.
  logic pv_a = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (val_a && !pv_a) begin
      check("a_expected_pending", int'(q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_mix", int'(mix_a), e.sample);
        check("a_latency", cyc - tick_cyc_a, e.lat);
      end
    end
    pv_a = val_a;
  end

  // Monitor B.
  logic pv_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (val_b && !pv_b) begin
      check("b_expected_pending", int'(q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_mix", int'(mix_b), e.sample);
        check("b_latency", cyc - tick_cyc_b, e.lat);
      end
    end
    pv_b = val_b;
  end

  task automatic push_a(input int s, input int l);
    exp_t e;
    e.sample = s;
    e.lat = l;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int s, input int l);
    exp_t e;
    e.sample = s;
    e.lat = l;
    q_b.push_back(e);
  endtask

  task automatic start_a();
    tick_a = 1'b1;
    tick_cyc_a = cyc + 1;
    @(negedge clk);
    tick_a = 1'b0;
  endtask

  task automatic start_b();
    tick_b = 1'b1;
    tick_cyc_b = cyc + 1;
    @(negedge clk);
    tick_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int bound);
    int n = 0;
    while (busy_a && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("a_reached_idle", int'(busy_a), 0);
  endtask

  task automatic wait_idle_b(input int bound);
    int n = 0;
    while (busy_b && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("b_reached_idle", int'(busy_b), 0);
  endtask

  task automatic wait_valid_a(input int bound);
    int n = 0;
    while (!val_a && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("a_reached_valid", int'(val_a), 1);
  endtask

  task automatic fill_tbl_a();
    for (int i = 0; i < 16; i++) tbl_a[i] = 10 * (i + 1);
  endtask

  initial begin
    int n_req;
    int bad;
    fill_tbl_a();
    for (int i = 0; i < 16; i++) tbl_b[i] = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy_a), 0);
    check("rst_valid", int'(val_a), 0);
    check("rst_mix", int'(mix_a), 0);
    check("rst_req", int'(req_a), 0);
    check("rst_sel", int'(sel_a), 0);
    check("rst_overrun", int'(ovr_a), 0);
    rst = 1'b0;
    @(negedge clk);

    // All voices, zero wait: 10+20+...+130 = 910.
    en_a = '1;
    wait_a = 0;
    rdy_a = 1'b1;
    push_a(910, 13);
    tick_a = 1'b1;
    tick_cyc_a = cyc + 1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      tick_a = 1'b0;
      check("t1_sel", int'(sel_a), i);
      check("t1_req", int'(req_a), 1);
    end
    wait_idle_a(10);

    // Voices 0 and 2 with three stall cycles each; stray acks on skipped voices must be ignored.
    en_a = 13'b0000000000101;
    tbl_a[0] = 200;
    tbl_a[2] = 55;
    wait_a = 3;
    junk_a = 1'b1;
    push_a(255, 19);
    start_a();
    n_req = 0;
    bad = 0;
    if (req_a) begin
      n_req++;
      if (sel_a != 0 && sel_a != 2) bad++;
    end
    for (int k = 0; k < 40 && !val_a; k++) begin
      @(negedge clk);
      if (req_a) begin
        n_req++;
        if (sel_a != 0 && sel_a != 2) bad++;
      end
    end
    check("t2_req_cycles", n_req, 8);
    check("t2_req_bad_sel", bad, 0);
    junk_a = 1'b0;
    wait_a = 0;
    wait_idle_a(5);
    fill_tbl_a();

    // 8-bit build: clamp is sticky and per addition.
    en_b = 13'b111;
    tbl_b[0] = 200;
    tbl_b[1] = 100;
    tbl_b[2] = 0;
    push_b(255, 13);
    start_b();
    wait_idle_b(20);
    en_b = 13'b11;
    tbl_b[0] = 100;
    tbl_b[1] = 155;
    push_b(255, 13);
    start_b();
    wait_idle_b(20);
    tbl_b[1] = 154;
    push_b(254, 13);
    start_b();
    wait_idle_b(20);

    // Overrun during SCAN, during OUT, and on the handshake cycle.
    en_a = '1;
    rdy_a = 1'b0;
    ovr_cnt = 0;
    push_a(910, 13);
    start_a();
    repeat (3) @(negedge clk);
    tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    wait_valid_a(20);
    repeat (2) @(negedge clk);
    tick_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_valid_held", int'(val_a), 1);
    check("t4_mix_held", int'(mix_a), 910);
    check("t4_busy_out", int'(busy_a), 1);
    rdy_a = 1'b1;
    tick_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    tick_a = 1'b0;
    check("t4_valid_dropped", int'(val_a), 0);
    check("t4_idle_after_hs", int'(busy_a), 0);
    @(negedge clk);
    check("t4_overrun_count", ovr_cnt, 3);
    check("t4_tick_on_hs_ignored", int'(busy_a), 0);
    en_a = 13'b1;
    tbl_a[0] = 7;
    rdy_a = 1'b1;
    push_a(7, 13);
    start_a();
    wait_idle_a(20);
    fill_tbl_a();

    // Asynchronous reset in the middle of a scan.
    en_a = '1;
    start_a();
    repeat (6) @(negedge clk);
    check("t5_sel_before", int'(sel_a), 6);
    check("t5_req_before", int'(req_a), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_req_async", int'(req_a), 0);
    check("t5_busy_async", int'(busy_a), 0);
    check("t5_valid_async", int'(val_a), 0);
    check("t5_mix_async", int'(mix_a), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    en_a = 13'h1000;
    push_a(130, 13);
    start_a();
    wait_idle_a(20);

    // Enable mask changes mid-scan; then an empty mix is still delivered.
    en_a = '1;
    push_a(910, 13);
    start_a();
    repeat (3) @(negedge clk);
    en_a = '0;
    wait_idle_a(20);
    push_a(0, 13);
    start_a();
    wait_idle_a(20);

    repeat (3) @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
